// File: rtl/pool_pkg.sv
// Shared constants and types for the pooling-layer sequencer.
package pool_pkg;

    localparam int unsigned POOL_L0_DIM = 24;
    localparam int unsigned POOL_L1_DIM = 8;
    localparam int unsigned POOL_L0_N_IN = POOL_L0_DIM * POOL_L0_DIM;
    localparam int unsigned POOL_L1_N_IN = POOL_L1_DIM * POOL_L1_DIM;
    localparam int unsigned POOL_L0_N_OUT = POOL_L0_N_IN / 4;
    localparam int unsigned POOL_L1_N_OUT = POOL_L1_N_IN / 4;

    typedef enum logic {
        LAYER0 = 1'b0,
        LAYER1 = 1'b1
    } layer_e;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_LOAD  = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_FIN   = 2'd3;

    // 2x2 stride-2 pooling yields one output per four inputs.
    function automatic int unsigned pool_n_out(input int unsigned n_in);
        return n_in / 4;
    endfunction

endpackage

// File: rtl/pool_watchdog.sv
// Idle-cycle watchdog: counts cycles since the last clear and flags expiry.
module pool_watchdog #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // cnt_q holds the number of cycles elapsed since the clearing event, counting the current one,
    // so expiry fires on the cycle whose edge would make the count reach TIMEOUT.
    assign expire = en && !clr && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = CW'(1);
        end else if (en && !expire) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pool_layer_ctrl.sv
// Sequencer that streams one feature map into maxpooling and collects the pooled results.
module pool_layer_ctrl
    import pool_pkg::*;
#(
    parameter int unsigned DW      = 8,
    parameter int unsigned AW      = 10,
    parameter int unsigned L0_DIM  = POOL_L0_DIM,
    parameter int unsigned L1_DIM  = POOL_L1_DIM,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          start,
    input  logic          layer,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          src_rd_en,
    output logic [AW-1:0] src_addr,
    input  logic [DW-1:0] src_data,
    output logic          pool_ivalid,
    output logic          pool_state,
    output logic [DW-1:0] pool_din,
    input  logic [DW-1:0] pool_dout,
    input  logic          pool_ovalid,
    output logic          dst_wr_en,
    output logic [AW-1:0] dst_addr,
    output logic [DW-1:0] dst_data
);

    localparam logic [AW-1:0] L0_N_IN  = AW'(L0_DIM * L0_DIM);
    localparam logic [AW-1:0] L1_N_IN  = AW'(L1_DIM * L1_DIM);
    localparam logic [AW-1:0] L0_N_OUT = AW'(pool_n_out(L0_DIM * L0_DIM));
    localparam logic [AW-1:0] L1_N_OUT = AW'(pool_n_out(L1_DIM * L1_DIM));

    state_t        state_q, state_d;
    layer_e        layer_q, layer_d;
    logic          err_q, err_d;
    logic [AW-1:0] rd_cnt_q, rd_cnt_d;
    logic [AW-1:0] out_cnt_q, out_cnt_d;
    logic          ivalid_q;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;

    logic [AW-1:0] n_in, n_out;
    logic          capture;
    logic          wd_clr, wd_en, wd_expire;

    assign n_in  = (layer_q == LAYER1) ? L1_N_IN  : L0_N_IN;
    assign n_out = (layer_q == LAYER1) ? L1_N_OUT : L0_N_OUT;

    assign capture = ((state_q == ST_LOAD) || (state_q == ST_DRAIN)) && pool_ovalid &&
                     (out_cnt_q != n_out);

    // Watchdog is held cleared outside DRAIN, so DRAIN entry restarts the idle count.
    assign wd_en  = (state_q == ST_DRAIN);
    assign wd_clr = !wd_en || pool_ovalid;

    pool_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rstn   (rstn),
        .clr    (wd_clr),
        .en     (wd_en),
        .expire (wd_expire)
    );

    always_comb begin
        state_d   = state_q;
        layer_d   = layer_q;
        err_d     = err_q;
        rd_cnt_d  = rd_cnt_q;
        out_cnt_d = out_cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        if (capture) begin
            wr_en_d   = 1'b1;
            wr_addr_d = out_cnt_q;
            wr_data_d = pool_dout;
            out_cnt_d = out_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    layer_d   = layer_e'(layer);
                    err_d     = 1'b0;
                    rd_cnt_d  = '0;
                    out_cnt_d = '0;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                rd_cnt_d = rd_cnt_q + 1'b1;
                if (rd_cnt_q == n_in - 1'b1) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_cnt_q == n_out) begin
                    state_d = ST_FIN;
                end else if (wd_expire) begin
                    err_d   = 1'b1;
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            layer_q   <= LAYER0;
            err_q     <= 1'b0;
            rd_cnt_q  <= '0;
            out_cnt_q <= '0;
            ivalid_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            layer_q   <= layer_d;
            err_q     <= err_d;
            rd_cnt_q  <= rd_cnt_d;
            out_cnt_q <= out_cnt_d;
            ivalid_q  <= src_rd_en;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign busy        = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
    assign done        = (state_q == ST_FIN);
    assign err         = err_q;
    assign src_rd_en   = (state_q == ST_LOAD);
    assign src_addr    = rd_cnt_q;
    assign pool_ivalid = ivalid_q;
    assign pool_state  = layer_q;
    // Gated so the pass-through reads as zero whenever no pixel is being presented.
    assign pool_din    = ivalid_q ? src_data : '0;
    assign dst_wr_en   = wr_en_q;
    assign dst_addr    = wr_addr_q;
    assign dst_data    = wr_data_q;

endmodule

// File: tb/tb_pool_layer_ctrl.sv
// Scoreboard bench for pool_layer_ctrl with a behavioural source buffer and maxpooling stub.
module tb_pool_layer_ctrl;

    localparam int DW = 8;
    localparam int AW = 10;
    localparam int TIMEOUT = 64;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          start = 1'b0;
    logic          layer = 1'b0;
    logic          busy, done, err;
    logic          src_rd_en;
    logic [AW-1:0] src_addr;
    logic [DW-1:0] src_data = '0;
    logic          pool_ivalid, pool_state;
    logic [DW-1:0] pool_din;
    logic [DW-1:0] pool_dout = '0;
    logic          pool_ovalid = 1'b0;
    logic          dst_wr_en;
    logic [AW-1:0] dst_addr;
    logic [DW-1:0] dst_data;

    always #5 clk = ~clk;

    pool_layer_ctrl #(
        .DW      (DW),
        .AW      (AW),
        .L0_DIM  (24),
        .L1_DIM  (8),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .layer       (layer),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .src_rd_en   (src_rd_en),
        .src_addr    (src_addr),
        .src_data    (src_data),
        .pool_ivalid (pool_ivalid),
        .pool_state  (pool_state),
        .pool_din    (pool_din),
        .pool_dout   (pool_dout),
        .pool_ovalid (pool_ovalid),
        .dst_wr_en   (dst_wr_en),
        .dst_addr    (dst_addr),
        .dst_data    (dst_data)
    );

    typedef struct {
        int addr;
        int data;
    } wr_t;

    typedef struct {
        int v;
        int rel;
    } pend_t;

    int   tests = 0;
    int   fails = 0;
    wr_t  exp_q[$];
    logic [7:0] mem [0:1023];

    int   cyc = 0, rd_cnt, rd_bad, exp_rd, iv_cnt, done_cnt, ps_bad, done_cyc, last_ov, last_rd;
    logic exp_ps;

    // Pool stub state
    pend_t pend[$];
    int    pix, emitted, max_out, lat, extra_left, n_out_m, dim_m, hold, mcyc = 0;
    int    rowmax [0:11];

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Scoreboard monitor
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (src_rd_en) begin
                if (int'(src_addr) != exp_rd) rd_bad++;
                exp_rd++;
                rd_cnt++;
                last_rd = cyc;
            end
            if (pool_ivalid) iv_cnt++;
            if ((busy || done) && pool_state != exp_ps) ps_bad++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (pool_ovalid) last_ov = cyc;
            if (dst_wr_en) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL dst_unexpected: write addr %0d data %0d, expected no write",
                             dst_addr, dst_data);
                end else begin
                    e = exp_q.pop_front();
                    check("dst_addr", int'(dst_addr), e.addr);
                    check("dst_data", int'(dst_data), e.data);
                end
            end
        end
    end

    // Source buffer (1-cycle read latency) and maxpooling stub
    initial begin
        logic          rd_s, iv_s;
        logic [AW-1:0] ad_s;
        int            din_s, r, c, pm, mx;
        pend_t         p;
        forever begin
            @(negedge clk);
            rd_s  = src_rd_en;
            ad_s  = src_addr;
            iv_s  = pool_ivalid;
            din_s = int'(pool_din);
            @(posedge clk);
            #1;
            mcyc++;
            if (rd_s) src_data = mem[ad_s];
            pool_ovalid = 1'b0;
            if (iv_s) begin
                r = pix / dim_m;
                c = pix % dim_m;
                if (c % 2 == 0) begin
                    hold = din_s;
                end else begin
                    pm = (hold > din_s) ? hold : din_s;
                    if (r % 2 == 0) begin
                        rowmax[c/2] = pm;
                    end else if (emitted < max_out) begin
                        mx = (rowmax[c/2] > pm) ? rowmax[c/2] : pm;
                        pend.push_back('{v: mx, rel: mcyc + lat - 1});
                        emitted++;
                    end
                end
                pix++;
            end
            if (pend.size() > 0 && pend[0].rel <= mcyc) begin
                p = pend.pop_front();
                pool_ovalid = 1'b1;
                pool_dout = DW'(p.v);
            end else if (pend.size() == 0 && emitted == n_out_m && extra_left > 0) begin
                pool_ovalid = 1'b1;
                pool_dout = 8'hEE;
                extra_left--;
            end
        end
    end

    task automatic setup(input logic lay, input int lat_i, input int max_i, input int extra_i);
        int dim, nin, nout, half, base, m;
        dim  = lay ? 8 : 24;
        nin  = dim * dim;
        nout = nin / 4;
        half = dim / 2;
        for (int i = 0; i < nin; i++) mem[i] = lay ? 8'(255 - i) : 8'(i % 256);
        exp_q.delete();
        for (int k = 0; k < nout && k < max_i; k++) begin
            base = 2 * (k / half) * dim + 2 * (k % half);
            m = int'(mem[base]);
            if (int'(mem[base + 1]) > m) m = int'(mem[base + 1]);
            if (int'(mem[base + dim]) > m) m = int'(mem[base + dim]);
            if (int'(mem[base + dim + 1]) > m) m = int'(mem[base + dim + 1]);
            exp_q.push_back('{addr: k, data: m});
        end
        rd_cnt = 0; rd_bad = 0; exp_rd = 0; iv_cnt = 0; done_cnt = 0; ps_bad = 0;
        done_cyc = 0; last_ov = 0; last_rd = 0;
        exp_ps = lay;
        pend.delete();
        pix = 0; emitted = 0; max_out = max_i; lat = lat_i; extra_left = extra_i;
        n_out_m = nout; dim_m = dim; hold = 0;
    endtask

    task automatic pulse_start(input logic lay);
        @(negedge clk);
        layer = lay;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done_cnt == 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == 0) check({name, "_done_timeout"}, 0, 1);
        repeat (12) @(negedge clk);
    endtask

    task automatic wait_addr(input int a);
        int n = 0;
        while (!(src_rd_en && int'(src_addr) == a) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("reach_addr", int'(src_addr), a);
    endtask

    task automatic final_checks(input int nin, input int err_exp);
        check("rd_count", rd_cnt, nin);
        check("rd_order", rd_bad, 0);
        check("ivalid_count", iv_cnt, nin);
        check("done_count", done_cnt, 1);
        check("err", int'(err), err_exp);
        check("pool_state_const", ps_bad, 0);
        check("wr_missing", exp_q.size(), 0);
        check("busy_idle", int'(busy), 0);
    endtask

    function automatic int nonzero_outputs();
        logic [42:0] v;
        v = {busy, done, err, src_rd_en, src_addr, pool_ivalid, pool_state, pool_din,
             dst_wr_en, dst_addr, dst_data};
        return $countones(v);
    endfunction

    initial begin
        int ref_cyc;
        // Reset state
        setup(1'b0, 1, 1000, 0);
        #2 rstn = 1'b0;
        #1 check("reset_outputs", nonzero_outputs(), 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("idle_after_reset", nonzero_outputs(), 0);

        // Layer 0, normal stream
        setup(1'b0, 1, 1000, 0);
        pulse_start(1'b0);
        wait_done("l0");
        final_checks(576, 0);

        // Layer 1, descending source
        setup(1'b1, 1, 1000, 0);
        pulse_start(1'b1);
        wait_done("l1");
        final_checks(64, 0);

        // Stub stops after 10 outputs, delivered late so the last ones land in DRAIN
        setup(1'b1, 40, 10, 0);
        pulse_start(1'b1);
        wait_done("timeout");
        final_checks(64, 1);
        ref_cyc = (last_ov > last_rd) ? last_ov : last_rd;
        check("timeout_gap", done_cyc - ref_cyc, 64);

        // Second start mid-LOAD with layer toggled is ignored
        setup(1'b1, 1, 1000, 0);
        pulse_start(1'b1);
        wait_addr(20);
        layer = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("midstart");
        final_checks(64, 0);

        // 150 ovalids on layer 0: only 144 writes
        setup(1'b0, 1, 1000, 6);
        pulse_start(1'b0);
        wait_done("extra");
        final_checks(576, 0);

        // Asynchronous reset mid-LOAD, then a clean rerun
        setup(1'b0, 1, 1000, 0);
        pulse_start(1'b0);
        wait_addr(300);
        rstn = 1'b0;
        #1 check("midrun_reset_outputs", nonzero_outputs(), 0);
        repeat (3) @(negedge clk);
        setup(1'b0, 1, 1000, 0);
        rstn = 1'b1;
        pulse_start(1'b0);
        wait_done("rerun");
        final_checks(576, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
